// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronise and debounce active-low push-buttons into level + press/release strobes; synchronise slide switches.
// Optional macro AUTOREPEAT_EN adds per-key auto-repeat press strobes while a key stays held.
module key_input_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 25000,
  parameter int REPEAT_PERIOD   = 5000
) (
  input  logic                CLOCK_50,
  input  logic                nReset,
  input  logic [N_KEYS-1:0]   KEY_n,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic [N_KEYS-1:0]   pressed,
  output logic [N_KEYS-1:0]   press_pulse,
  output logic [N_KEYS-1:0]   release_pulse,
  output logic [SW_WIDTH-1:0] SW_sync
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_input_conditioner: parameter out of range");
  end
  logic [N_KEYS-1:0] key_m_q, key_s_q, pressed_q, press_q, release_q;
  logic [SW_WIDTH-1:0] sw_m_q, sw_s_q;
  logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_KEYS-1:0] key_s, flip, rise, fall, rep_fire;
  assign key_s = ~key_s_q;
  // counter runs only while the synchronised key disagrees with the accepted level
  always_comb begin
    flip  = '0;
    cnt_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      flip[i]  = key_s[i] != pressed_q[i] && cnt_q[i] + CW'(1) == DB_LAST;
      cnt_d[i] = (key_s[i] == pressed_q[i] || flip[i]) ? '0 : cnt_q[i] + CW'(1);
    end
  end
  assign rise = flip & ~pressed_q;
  assign fall = flip & pressed_q;
`ifdef AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_e;
  rep_state_e st_q [N_KEYS];
  logic [RW-1:0] rcnt_q [N_KEYS];
  // a falling key suppresses any repeat that would land in the release cycle
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_KEYS; i++)
      rep_fire[i] = !fall[i] && st_q[i] != IDLE &&
                    rcnt_q[i] + RW'(1) == (st_q[i] == HOLD ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD));
  end
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        st_q[i]   <= IDLE;
        rcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        st_q[i]   <= fall[i] ? IDLE : rise[i] ? HOLD : rep_fire[i] ? REPEAT : st_q[i];
        rcnt_q[i] <= (st_q[i] == IDLE || rise[i] || fall[i] || rep_fire[i]) ? '0 : rcnt_q[i] + RW'(1);
      end
    end
  end
`else
  assign rep_fire = '0;
`endif
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      key_m_q   <= '1;
      key_s_q   <= '1;
      sw_m_q    <= '0;
      sw_s_q    <= '0;
      cnt_q     <= '0;
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      key_m_q   <= KEY_n;
      key_s_q   <= key_m_q;
      sw_m_q    <= SW_raw;
      sw_s_q    <= sw_m_q;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_q ^ flip;
      press_q   <= rise | rep_fire;
      release_q <= fall;
    end
  end
  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign SW_sync       = sw_s_q;
endmodule

// File: tb/tb_key_input_conditioner.sv
// tb_key_input_conditioner: directed checks of reset, debounce latency, bounce rejection, multi-key, mid-press reset and repeat.
module tb_key_input_conditioner;
  logic CLOCK_50 = 1'b0;
  logic nReset = 1'b0;
  logic [1:0] KEY_n = 2'b11;
  logic [9:0] SW_raw = 10'h3FF;
  logic [1:0] pressed, press_pulse, release_pulse;
  logic [9:0] SW_sync;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int npress [2] = '{0, 0};
  int nrel [2] = '{0, 0};
  int lastp [2] = '{0, 0};
  int lastr [2] = '{0, 0};
  int nboth = 0;
  int nsim = 0;

  key_input_conditioner #(
    .N_KEYS(2), .SW_WIDTH(10), .DEBOUNCE_CYCLES(1000), .REPEAT_DELAY(3000), .REPEAT_PERIOD(1000)
  ) dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset), .KEY_n(KEY_n), .SW_raw(SW_raw),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse), .SW_sync(SW_sync)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // strobe log: at the negedge after edge k, cyc == k
  always @(negedge CLOCK_50) begin
    for (int i = 0; i < 2; i++) begin
      if (press_pulse[i]) begin
        npress[i] <= npress[i] + 1;
        lastp[i]  <= cyc;
      end
      if (release_pulse[i]) begin
        nrel[i]  <= nrel[i] + 1;
        lastr[i] <= cyc;
      end
    end
    if (press_pulse == 2'b11) nboth <= nboth + 1;
    if (|(press_pulse & release_pulse)) nsim <= nsim + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
    #1;
  endtask

  initial begin
    int c, p0, p1, r0, r1, b0, a;
    // reset state and switch synchroniser
    tick(3);
    chk("rst_pressed", pressed, 0);
    chk("rst_press_pulse", press_pulse, 0);
    chk("rst_release_pulse", release_pulse, 0);
    chk("rst_sw_sync", SW_sync, 0);
    nReset = 1'b1;
    tick(1);
    chk("sw_after_1_edge", SW_sync, 0);
    tick(1);
    chk("sw_after_2_edges", SW_sync, 10'h3FF);
    // clean press/release on key 0
    p0 = npress[0];
    c = cyc;
    KEY_n[0] = 1'b0;
    tick(1500);
    chk("t2_press_count", npress[0] - p0, 1);
    chk("t2_press_cycle", lastp[0], c + 1002);
    chk("t2_pressed", pressed, 2'b01);
    r0 = nrel[0];
    c = cyc;
    KEY_n[0] = 1'b1;
    tick(1100);
    chk("t2_release_count", nrel[0] - r0, 1);
    chk("t2_release_cycle", lastr[0], c + 1002);
    chk("t2_pressed_after", pressed, 0);
    chk("t2_key1_quiet", npress[1] + nrel[1], 0);
    // bouncy press on key 1
    p1 = npress[1];
    r1 = nrel[1];
    for (int k = 0; k < 4; k++) begin
      KEY_n[1] = 1'b0;
      tick(100);
      KEY_n[1] = 1'b1;
      tick(100);
    end
    chk("t3_bounce_quiet", npress[1] + nrel[1] - p1 - r1, 0);
    c = cyc;
    KEY_n[1] = 1'b0;
    tick(1500);
    chk("t3_press_count", npress[1] - p1, 1);
    chk("t3_press_cycle", lastp[1], c + 1002);
    chk("t3_pressed", pressed, 2'b10);
    KEY_n[1] = 1'b1;
    tick(1100);
    chk("t3_release_count", nrel[1] - r1, 1);
    // simultaneous press, staggered release
    p0 = npress[0];
    p1 = npress[1];
    b0 = nboth;
    c = cyc;
    KEY_n = 2'b00;
    tick(1100);
    chk("t4_both_strobe", nboth - b0, 1);
    chk("t4_press_counts", (npress[0] - p0) * 2 + (npress[1] - p1), 3);
    chk("t4_press_cycle", lastp[1], c + 1002);
    c = cyc;
    KEY_n[0] = 1'b1;
    tick(50);
    KEY_n[1] = 1'b1;
    tick(1100);
    chk("t4_release0_cycle", lastr[0], c + 1002);
    chk("t4_release_gap", lastr[1] - lastr[0], 50);
    // reset 500 cycles into an accepted press
    p0 = npress[0];
    r0 = nrel[0];
    KEY_n[0] = 1'b0;
    tick(1002 + 500);
    chk("t5_pressed_before", pressed, 2'b01);
    nReset = 1'b0;
    #1;
    chk("t5_pressed_cleared", pressed, 0);
    chk("t5_sw_cleared", SW_sync, 0);
    tick(3);
    nReset = 1'b1;
    c = cyc;
    tick(1100);
    chk("t5_press_count", npress[0] - p0, 2);
    chk("t5_repress_cycle", lastp[0], c + 1002);
    KEY_n[0] = 1'b1;
    tick(1100);
    chk("t5_release_count", nrel[0] - r0, 1);
    // long hold: repeat strobes only with AUTOREPEAT_EN
    p0 = npress[0];
    r0 = nrel[0];
    c = cyc;
    a = c + 1002;
    KEY_n[0] = 1'b0;
    tick(1002 + 6000);
`ifdef AUTOREPEAT_EN
    chk("t6_press_count", npress[0] - p0, 5);
    chk("t6_last_press", lastp[0], a + 6000);
`else
    chk("t6_press_count", npress[0] - p0, 1);
    chk("t6_last_press", lastp[0], a);
`endif
    KEY_n[0] = 1'b1;
    tick(1100);
    chk("t6_release_count", nrel[0] - r0, 1);
    chk("never_press_and_release", nsim, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Input conditioning stage directly upstream of the de1_soc_wrapper core logic.
- Takes raw active-low DE1-SoC push-buttons and raw slide switches.
- Per key: synchronises, debounces and emits a clean level plus single-cycle press and release strobes.
- Switches: synchronises only. Downstream logic consumes the strobes as "write" (key 0) and "read" (key 1) commands.

Parameters:
N_KEYS, 2, number of push-buttons conditioned
SW_WIDTH, 10, number of slide switches synchronised
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised cycles required to accept a key change (20 us at 50 MHz); legal range 2..2^20
REPEAT_DELAY, 25000, cycles a key must stay held before the first auto-repeat strobe (used only with AUTOREPEAT_EN)
REPEAT_PERIOD, 5000, cycles between successive auto-repeat strobes (used only with AUTOREPEAT_EN)

Ports:
CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge
nReset  input  1  asynchronous active-low reset
KEY_n  input  N_KEYS  raw push-buttons, active low (0 = pressed), asynchronous to CLOCK_50
SW_raw  input  SW_WIDTH  raw slide switches, asynchronous
pressed  output  N_KEYS  debounced level, 1 = key held
press_pulse  output  N_KEYS  one-cycle strobe on accepted press (and on auto-repeat if enabled)
release_pulse  output  N_KEYS  one-cycle strobe on accepted release
SW_sync  output  SW_WIDTH  two-flop synchronised switches

Behaviour:
- Clock and reset: single clock domain, CLOCK_50. Reset is asynchronous assert, synchronous-deassert-safe (flops clear immediately on nReset low).
- Reset values:
  - KEY synchroniser flops = 1 (released).
  - SW synchroniser flops = 0.
  - pressed = 0, press_pulse = 0, release_pulse = 0, SW_sync = 0.
  - All counters = 0.
- Synchroniser: KEY_n[i] and SW_raw pass through 2 flops each. key_s[i] = ~(second stage), i.e. active-high synchronised key.
- Debounce, per key, independent:
  - Counter width = $clog2(DEBOUNCE_CYCLES+1).
  - Each cycle key_s[i] == pressed[i]: counter cleared to 0.
  - Each cycle key_s[i] != pressed[i]: counter increments.
  - When the counter would reach DEBOUNCE_CYCLES: pressed[i] toggles and the counter clears.
  - The counter never wraps.
- Latency: a clean edge on KEY_n sampled at rising edge E0 changes pressed at edge E0 + 2 + DEBOUNCE_CYCLES − 1 (DEBOUNCE_CYCLES+1 edges after E0). This is exact, with no jitter.
- Strobes:
  - press_pulse[i] is registered and high for exactly the one cycle in which pressed[i] rises.
  - release_pulse[i] is registered and high for exactly the one cycle in which pressed[i] falls.
  - The two are never simultaneously high for one key.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no level change and no strobe.
- Multiple keys: keys are fully independent. Simultaneous presses give simultaneous strobes on the same cycle.
- Reset mid-operation:
  - All outputs clear immediately.
  - A key still held when nReset rises is seen as a new press and strobes after the full debounce latency.
- SW_sync: value of SW_raw delayed 2 edges, no debounce.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- With the macro, per-key repeat FSM:
  - States: IDLE, HOLD, REPEAT.
  - IDLE → HOLD on the rising edge of pressed; the repeat counter clears.
  - HOLD: the counter counts up. When it reaches REPEAT_DELAY, press_pulse fires one cycle, the counter clears, and the FSM moves to REPEAT.
  - REPEAT: press_pulse fires every REPEAT_PERIOD cycles.
  - Any state → IDLE the cycle pressed falls. No repeat strobe may coincide with release_pulse.
  - Reset → IDLE.
- Without the macro:
  - No FSM or repeat counters are synthesised.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - press_pulse fires exactly once per accepted press.

Test Plan:
1. Reset with KEY_n = 11, SW_raw = 0x3FF → all outputs 0 during reset. SW_sync = 0x3FF exactly 2 edges after nReset rises. No strobes.
2. Clean 30 us press on key 0 (1500 cycles low), DEBOUNCE_CYCLES = 1000 → press_pulse[0] is a single cycle 1001 edges after the first low sample. pressed[0] high until 1001 edges after release. One release_pulse[0]. key 1 outputs stay 0.
3. Bouncy press: KEY_n[1] toggles low/high every 100 cycles for 800 cycles, then held low 1500 cycles → exactly one press_pulse[1], 1001 edges after the start of the final low hold. No strobes during the bounce.
4. Both keys pressed on the same edge → press_pulse = 2'b11 on one cycle. Releases 50 cycles apart → two release_pulse strobes 50 cycles apart.
5. nReset pulsed low at cycle 500 of a held press → pressed clears immediately. After reset, press_pulse fires 1001 edges after the first post-reset sample.
6. AUTOREPEAT_EN with REPEAT_DELAY = 3000, REPEAT_PERIOD = 1000, key held 6000 cycles after acceptance → press_pulse at acceptance, then at +3000, +4000, +5000, +6000 relative to acceptance. No strobe in the release cycle. Without the macro → only the acceptance strobe.
